// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// Default operand widths, FSM state encoding and counter width.
package divider_pkg;

    localparam int DW_DEF = 8;
    localparam int VW_DEF = 4;
    localparam int CNT_W  = $clog2(DW_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/seq_divider_8x4.sv
// Purpose: unsigned restoring divider, DW-bit dividend by VW-bit divisor, one quotient bit per clock.
// Latency: done pulses DW cycles after the accepting edge; 1 cycle for a zero divisor.
// Backpressure: start is only sampled in IDLE; start and operand changes while busy are ignored.
module seq_divider_8x4
    import divider_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    // Never narrower than the package default so DW=1 still gets a usable counter.
    localparam int CW = ($clog2(DW) > CNT_W) ? $clog2(DW) : CNT_W;

    state_t          state, state_nxt;
    logic [DW-1:0]   shreg;
    logic [VW:0]     rem;
    logic [VW-1:0]   dvsr;
    logic [CW-1:0]   cnt;

    logic            accept;
    logic            finish;
    logic            zero_div;

    logic [VW:0]     shifted;
    logic [VW+1:0]   trial_w;
    logic            q_bit;
    logic [VW:0]     rem_nxt;
    logic [DW:0]     shreg_ext;
    logic [DW-1:0]   shreg_nxt;

    // A set rem MSB means the shifted value exceeds any divisor, so subtraction always succeeds.
    always_comb begin
        shifted   = {rem[VW-1:0], shreg[DW-1]};
        trial_w   = {1'b0, shifted} - {2'b00, dvsr};
        q_bit     = rem[VW] | ~trial_w[VW+1];
        rem_nxt   = q_bit ? trial_w[VW:0] : shifted;
        shreg_ext = {shreg, q_bit};
        shreg_nxt = shreg_ext[DW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        zero_div  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        zero_div = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg       <= '0;
            rem         <= '0;
            dvsr        <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= finish | zero_div;
            if (accept) begin
                shreg <= dividend;
                dvsr  <= divisor;
                rem   <= '0;
                cnt   <= CW'(DW - 1);
            end else if (state == RUN) begin
                shreg <= shreg_nxt;
                rem   <= rem_nxt;
                cnt   <= cnt - 1'b1;
            end
            if (finish) begin
                quotient    <= shreg_nxt;
                remainder   <= rem_nxt[VW-1:0];
                div_by_zero <= 1'b0;
            end else if (zero_div) begin
                quotient    <= '1;
                remainder   <= '1;
                div_by_zero <= 1'b1;
            end
        end
    end

endmodule
